// File: rtl/ifetch_resp_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch responder.
//   state_e  : responder FSM states
//   NOP      : instruction returned on any fetch fault (addi x0,x0,0)
//   CNT_W    : width of the bus timeout counter
//   sat_inc  : saturating increment for the timeout counter
package ifetch_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RD,
    HOLD,
    DROP
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/ifetch_resp_if.sv
// ifetch_resp_if: fetch-side, memory-bus and decode-side signals of the
// instruction-fetch responder.
//   slave  : the responder view (takes fetch_req/bus responses, drives
//            fetch_gnt, mem_req/mem_addr and the instruction output)
//   master : the surrounding core / bus / decoder view
interface ifetch_resp_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_gnt;
  logic            flush;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_fault;

  modport slave (
    input  fetch_req, fetch_pc, flush,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  instr_ready,
    output fetch_gnt, mem_req, mem_addr,
    output instr_valid, instr, instr_pc, instr_fault
  );

  modport master (
    output fetch_req, fetch_pc, flush,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output instr_ready,
    input  fetch_gnt, mem_req, mem_addr,
    input  instr_valid, instr, instr_pc, instr_fault
  );

endinterface

// File: rtl/ifetch_resp_out_reg.sv
// ifetch_out_reg: output stage of the fetch responder. Holds instr, instr_pc
// and instr_fault and the valid flag of the valid/ready handshake to decode.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : drop the held instruction (valid only; data is kept)
//   load_i        : capture instr_i/pc_i/fault_i and raise valid
//   ready_i       : decode consumes the held instruction
//   valid_o, instr_o, pc_o, fault_o : output stage towards decode
module ifetch_out_reg
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            fault_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fault_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, pc_q;
  logic            fault_q;

  // A load coincides with a consume on a HOLD-accept overlap with a
  // misaligned fault; the new instruction must survive, so load wins.
  always_comb begin
    valid_d = valid_q;
    if (flush_i)      valid_d = 1'b0;
    else if (load_i)  valid_d = 1'b1;
    else if (ready_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= XLEN'(NOP);
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
        fault_q <= fault_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/ifetch_resp.sv
// ifetch_resp: instruction-fetch responder. Accepts a PC, performs one word
// read on the instruction-memory bus and presents the instruction to decode.
// Handles redirect flushes, bus errors and read timeouts.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ifetch_resp_if.slave (fetch req/gnt, flush, memory bus,
//                instruction valid/ready output)
// Build option: IFETCH_ALIGN_CHECK_EN -- a fetch_pc with non-zero [1:0] is
// answered with an immediate fault (NOP) and no bus access. Without it the
// low PC bits are ignored and the aligned word is fetched.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_resp_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              gnt;
  logic              accept;
  logic              misalign;
  logic              load;
  logic [XLEN-1:0]   ld_instr;
  logic [XLEN-1:0]   ld_pc;
  logic              ld_fault;

  assign gnt = rst_n && !bus.flush &&
               (state_q == IDLE || (state_q == HOLD && bus.instr_ready));
  assign bus.fetch_gnt = gnt;
  assign accept        = gnt && bus.fetch_req;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = |bus.fetch_pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  assign bus.mem_req  = (state_q == WAIT_GNT);
  assign bus.mem_addr = {pc_q[XLEN-1:2], 2'b00};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    ld_instr = XLEN'(NOP);
    ld_pc    = pc_q;
    ld_fault = 1'b0;

    if (bus.flush) begin
      // A read already granted must still be drained off the bus.
      if (state_q == WAIT_RD || state_q == DROP) begin
        state_d = DROP;
        cnt_d   = sat_inc(cnt_q);
      end else begin
        state_d = IDLE;
      end
    end else if (accept) begin
      pc_d = bus.fetch_pc;
      if (misalign) begin
        state_d  = HOLD;
        load     = 1'b1;
        ld_pc    = bus.fetch_pc;
        ld_fault = 1'b1;
      end else begin
        state_d = WAIT_GNT;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        WAIT_GNT: begin
          if (bus.mem_gnt) begin
            state_d = WAIT_RD;
            cnt_d   = '0;
          end
        end
        WAIT_RD: begin
          if (bus.mem_rvalid) begin
            state_d  = HOLD;
            load     = 1'b1;
            ld_fault = bus.mem_err;
            ld_instr = bus.mem_err ? XLEN'(NOP) : bus.mem_rdata;
          end else if (cnt_q >= TMO_LAST) begin
            state_d  = HOLD;
            load     = 1'b1;
            ld_fault = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        HOLD: begin
          if (bus.instr_ready) state_d = IDLE;
        end
        DROP: begin
          // >= rather than ==: a flush in WAIT_RD may push the count past
          // the limit before DROP first checks it.
          if (bus.mem_rvalid || cnt_q >= TMO_LAST) state_d = IDLE;
          else                                     cnt_d   = sat_inc(cnt_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  ifetch_out_reg #(
    .XLEN(XLEN)
  ) u_out (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (bus.flush),
    .load_i  (load),
    .instr_i (ld_instr),
    .pc_i    (ld_pc),
    .fault_i (ld_fault),
    .ready_i (bus.instr_ready),
    .valid_o (bus.instr_valid),
    .instr_o (bus.instr),
    .pc_o    (bus.instr_pc),
    .fault_o (bus.instr_fault)
  );

endmodule

// File: tb/tb_ifetch_resp.sv
// Testbench for ifetch_resp: cycle vector table, directed corner sequences
// and a randomized run against a transaction-level scoreboard.
module tb_ifetch_resp;
  import ifetch_pkg::*;

  localparam int unsigned TMO  = 8;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_resp_if #(.XLEN(32)) bus ();

  ifetch_resp #(
    .XLEN           (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        fl, g, rv;
    logic [31:0] rd;
    logic        er, rdy;
    logic        e_gnt, e_mreq;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pc;
    logic        e_fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  vec_t        vt[25];
  exp_t        sb[$];
  bit          outst       = 1'b0;
  int          lat         = 0;
  bit          req_pending = 1'b0;
  logic [31:0] last_addr   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] pc, input logic fl,
                       input logic g, input logic rv, input logic [31:0] rd,
                       input logic er, input logic rdy);
    bus.fetch_req   = req;
    bus.fetch_pc    = pc;
    bus.flush       = fl;
    bus.mem_gnt     = g;
    bus.mem_rvalid  = rv;
    bus.mem_rdata   = rd;
    bus.mem_err     = er;
    bus.instr_ready = rdy;
  endtask

  function automatic vec_t mk(input logic req, input logic [31:0] pc, input logic fl,
                              input logic g, input logic rv, input logic [31:0] rd,
                              input logic er, input logic rdy, input logic eg,
                              input logic emr, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.req = req; v.pc = pc; v.fl = fl; v.g = g; v.rv = rv; v.rd = rd; v.er = er;
    v.rdy = rdy; v.e_gnt = eg; v.e_mreq = emr; v.e_addr = ea; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_fault = ef;
    return v;
  endfunction

  // Behavioural instruction memory: contents and error flag per word address.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic merr(input logic [31:0] a);
    logic [31:0] w;
    w = memw(a);
    return (w[7:4] == 4'hF);
  endfunction

  function automatic exp_t expect_for(input logic [31:0] pc);
    exp_t        e;
    logic [31:0] a;
    a    = pc & 32'hFFFF_FFFC;
    e.pc = pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      e.instr = NOPW;
      e.fault = 1'b1;
      return e;
    end
`endif
    e.fault = merr(a);
    e.instr = e.fault ? NOPW : memw(a);
    return e;
  endfunction

  // One random cycle: bus responder with 1..3 cycle read latency, random
  // fetch requests and decode back-pressure; results go through sb.
  task automatic rnd_cycle(input bit allow_req);
    logic [31:0] pc;
    logic [31:0] oa;
    exp_t        e;
    pc = $urandom;
    if ($urandom_range(0, 3) != 0) pc = pc & 32'hFFFF_FFFC;
    bus.fetch_req   = allow_req && ($urandom_range(0, 9) < 7);
    bus.fetch_pc    = pc;
    bus.flush       = 1'b0;
    bus.instr_ready = allow_req ? ($urandom_range(0, 9) < 6) : 1'b1;
    bus.mem_gnt     = !outst && ($urandom_range(0, 1) == 1);
    oa              = last_addr;
    if (outst && lat == 1) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = memw(oa);
      bus.mem_err    = merr(oa);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = $urandom;
      bus.mem_err    = 1'b0;
    end
    settle();
    if (bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_extra: got instr %h pc %h expected no instruction", bus.instr, bus.instr_pc);
      end else begin
        e = sb.pop_front();
        chk("rnd_instr", bus.instr, e.instr);
        chk("rnd_pc", bus.instr_pc, e.pc);
        chk("rnd_fault", {31'b0, bus.instr_fault}, {31'b0, e.fault});
      end
    end
    if (req_pending) chk("rnd_req_held", {31'b0, bus.mem_req}, 32'd1);
    if (bus.mem_req) chk("rnd_addr", bus.mem_addr, last_addr);
    if (bus.fetch_req && bus.fetch_gnt) begin
      sb.push_back(expect_for(pc));
      last_addr = pc & 32'hFFFF_FFFC;
    end
    req_pending = bus.mem_req && !bus.mem_gnt;
    if (bus.mem_req && bus.mem_gnt) begin
      outst = 1'b1;
      lat   = $urandom_range(1, 3);
    end else if (outst) begin
      if (bus.mem_rvalid) outst = 1'b0;
      else                lat--;
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(1, 32'h0, 0, 0, 0, 32'h0, 0, 0,  1, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[1] = mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0,  0, 1, 32'h0, 0, NOPW, 32'h0, 0);
    vt[2] = mk(0, 32'h0, 0, 0, 1, 32'h0050_0093, 0, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    for (int i = 3; i <= 7; i++)
      vt[i] = mk(1, 32'h10, 0, 0, 0, 32'h0, 0, 0,  0, 0, 32'h0, 1, 32'h0050_0093, 32'h0, 0);
    vt[8]  = mk(1, 32'h10, 0, 0, 0, 32'h0, 0, 1,  1, 0, 32'h0, 1, 32'h0050_0093, 32'h0, 0);
    vt[9]  = mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0,  0, 1, 32'h10, 0, NOPW, 32'h0, 0);
    vt[10] = mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[11] = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[12] = mk(0, 32'h0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[13] = mk(1, 32'h4, 0, 0, 0, 32'h0, 0, 0,  1, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[14] = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0,  0, 1, 32'h4, 0, NOPW, 32'h0, 0);
    vt[15] = mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0,  0, 1, 32'h4, 0, NOPW, 32'h0, 0);
    vt[16] = mk(0, 32'h0, 0, 0, 1, 32'h00A0_0113, 0, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[17] = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1,  1, 0, 32'h0, 1, 32'h00A0_0113, 32'h4, 0);
    vt[18] = mk(1, 32'h8, 0, 0, 0, 32'h0, 0, 0,  1, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[19] = mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0,  0, 1, 32'h8, 0, NOPW, 32'h0, 0);
    vt[20] = mk(0, 32'h0, 0, 0, 1, 32'h1234_5678, 1, 0,  0, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[21] = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 1,  1, 0, 32'h0, 1, NOPW, 32'h8, 1);
    vt[22] = mk(1, 32'hC, 0, 0, 0, 32'h0, 0, 0,  1, 0, 32'h0, 0, NOPW, 32'h0, 0);
    vt[23] = mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0,  0, 1, 32'hC, 0, NOPW, 32'h0, 0);
    vt[24] = mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0,  1, 0, 32'h0, 0, NOPW, 32'h0, 0);

    // Reset: fetch_gnt must stay low even with a request pending.
    drive(1, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    rst_n = 1'b0;
    tick();
    settle();
    chk("rst_fetch_gnt", {31'b0, bus.fetch_gnt}, 32'd0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, NOPW);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_fault", {31'b0, bus.instr_fault}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Cycle table: basic fetch, HOLD stall, flush+drop, error, flush in WAIT_GNT.
    for (int i = 0; i < 25; i++) begin
      drive(vt[i].req, vt[i].pc, vt[i].fl, vt[i].g, vt[i].rv, vt[i].rd, vt[i].er, vt[i].rdy);
      settle();
      chk($sformatf("vec%0d_fetch_gnt", i), {31'b0, bus.fetch_gnt}, {31'b0, vt[i].e_gnt});
      chk($sformatf("vec%0d_mem_req", i), {31'b0, bus.mem_req}, {31'b0, vt[i].e_mreq});
      if (vt[i].e_mreq) chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, bus.instr_valid}, {31'b0, vt[i].e_valid});
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d_instr", i), bus.instr, vt[i].e_instr);
        chk($sformatf("vec%0d_instr_pc", i), bus.instr_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_fault", i), {31'b0, bus.instr_fault}, {31'b0, vt[i].e_fault});
      end
      tick();
    end

    // Timeout: no rvalid for TMO cycles, then a late rvalid is ignored.
    drive(1, 32'h20, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("tmo_accept", {31'b0, bus.fetch_gnt}, 32'd1);
    tick();
    drive(0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
    settle();
    chk("tmo_mem_addr", bus.mem_addr, 32'h20);
    tick();
    for (int i = 0; i < int'(TMO); i++) begin
      drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
      settle();
      chk("tmo_wait_valid", {31'b0, bus.instr_valid}, 32'd0);
      tick();
    end
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("tmo_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("tmo_fault", {31'b0, bus.instr_fault}, 32'd1);
    chk("tmo_instr", bus.instr, NOPW);
    chk("tmo_instr_pc", bus.instr_pc, 32'h20);
    tick();
    drive(0, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 0, 0);
    settle();
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("late_hold_instr", bus.instr, NOPW);
    chk("late_hold_fault", {31'b0, bus.instr_fault}, 32'd1);
    chk("late_hold_valid", {31'b0, bus.instr_valid}, 32'd1);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    settle();
    tick();
    drive(0, 32'h0, 0, 0, 1, 32'hCAFE_F00D, 0, 0);
    settle();
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("late_idle_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("late_idle_mem_req", {31'b0, bus.mem_req}, 32'd0);
    tick();

    // Misaligned PC.
    drive(1, 32'h6, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("mis_accept", {31'b0, bus.fetch_gnt}, 32'd1);
    tick();
`ifdef IFETCH_ALIGN_CHECK_EN
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("mis_no_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("mis_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("mis_fault", {31'b0, bus.instr_fault}, 32'd1);
    chk("mis_instr", bus.instr, NOPW);
    chk("mis_instr_pc", bus.instr_pc, 32'h6);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    settle();
    tick();
`else
    drive(0, 32'h0, 0, 1, 0, 32'h0, 0, 0);
    settle();
    chk("mis_mem_req", {31'b0, bus.mem_req}, 32'd1);
    chk("mis_mem_addr", bus.mem_addr, 32'h4);
    tick();
    drive(0, 32'h0, 0, 0, 1, 32'h0070_0193, 0, 0);
    settle();
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 1);
    settle();
    chk("mis_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("mis_instr", bus.instr, 32'h0070_0193);
    chk("mis_instr_pc", bus.instr_pc, 32'h6);
    chk("mis_fault", {31'b0, bus.instr_fault}, 32'd0);
    tick();
`endif
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("mis_done_valid", {31'b0, bus.instr_valid}, 32'd0);

    // Reset while in WAIT_GNT.
    drive(1, 32'h40, 0, 0, 0, 32'h0, 0, 0);
    settle();
    tick();
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    settle();
    chk("rstw_mem_req_before", {31'b0, bus.mem_req}, 32'd1);
    tick();
    settle();
    chk("rstw_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rstw_mem_addr", bus.mem_addr, 32'h0);
    chk("rstw_valid", {31'b0, bus.instr_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Randomized run against the scoreboard, then drain.
    for (int i = 0; i < 400; i++) rnd_cycle(1'b1);
    for (int i = 0; i < 100 && (sb.size() != 0 || outst); i++) rnd_cycle(1'b0);
    chk("drain_empty", sb.size(), 32'd0);
    drive(0, 32'h0, 0, 0, 0, 32'h0, 0, 0);
    settle();
    chk("drain_valid", {31'b0, bus.instr_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_resp.md
# ifetch_resp

Instruction-fetch responder for the single-cycle RISC-V core. It accepts the PC emitted by the PC register, performs one word read on the instruction-memory bus (grant plus variable-latency read data) and returns the instruction to decode over a valid/ready handshake. It handles redirect flushes, misaligned PCs and bus timeouts, and sits between the PC register and the decoder.

## Interface
Parameters:
- XLEN, 32, address and data width.
- TIMEOUT_CYCLES, 16, number of cycles waited in WAIT_RD for mem_rvalid before a fault is reported; legal range 2..255.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset; synchronous and active-low.
- fetch_req  in  1  PC valid from the PC register.
- fetch_pc  in  XLEN  address to fetch.
- fetch_gnt  out  1  request accepted this cycle.
- flush  in  1  redirect; discard all in-flight and held work.
- mem_req  out  1  bus read request.
- mem_addr  out  XLEN  word address; bits [1:0] are always 0.
- mem_gnt  in  1  bus accepted the request.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  XLEN  read data.
- mem_err  in  1  bus error; qualified by mem_rvalid.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode consumes the instruction.
- instr  out  XLEN  instruction word.
- instr_pc  out  XLEN  PC of the instruction.
- instr_fault  out  1  fetch fault (misaligned, bus error or timeout).

## Operation
- States: IDLE, WAIT_GNT, WAIT_RD, HOLD, DROP.
- fetch_gnt = !flush && (state==IDLE || (state==HOLD && instr_ready)).
- On accept:
  - fetch_pc is captured into pc_q; next state is WAIT_GNT.
  - With the misalignment check active and fetch_pc[1:0]!=0, no bus access is made. Next state is HOLD with instr_fault=1 and instr=NOP (32'h00000013).
- WAIT_GNT:
  - mem_req=1 and mem_addr={pc_q[XLEN-1:2],2'b00}.
  - mem_gnt -> WAIT_RD, and the timeout counter clears.
  - mem_req is held until mem_gnt or flush; it is never withdrawn otherwise.
- WAIT_RD:
  - mem_rvalid -> HOLD with instr=mem_rdata and instr_fault=mem_err. If mem_err=1, instr=NOP.
  - When the counter reaches TIMEOUT_CYCLES-1 without mem_rvalid -> HOLD with fault and NOP. The transaction is abandoned.
- HOLD:
  - instr_valid=1; instr, instr_pc and instr_fault stay stable until instr_ready.
  - instr_ready without a new accept -> IDLE. With a same-cycle accept -> WAIT_GNT (or HOLD on a misaligned fault).
- Flush, which has priority over every other event:
  - IDLE, WAIT_GNT or HOLD -> IDLE; mem_req and instr_valid drop the next cycle.
  - WAIT_RD -> DROP.
  - DROP waits for mem_rvalid, discards it, then -> IDLE. A flush while in DROP stays in DROP.
  - The timeout counter also runs in DROP; expiry -> IDLE.
- mem_rvalid is ignored in IDLE, WAIT_GNT and HOLD, for example a late response after a timeout.
- One outstanding bus transaction at most.

## Timing
- Reset values: state=IDLE, fetch_gnt=0 during reset, mem_req=0, mem_addr=0, instr_valid=0, instr=NOP, instr_pc=0, instr_fault=0, counter=0.
- Reset mid-transaction returns to IDLE immediately. No DROP is performed; the bus is reset together with this block.
- Minimum latency from accept to instr_valid: 3 cycles with zero-wait mem_gnt and next-cycle mem_rvalid (accept -> WAIT_GNT -> WAIT_RD -> HOLD).
- A misaligned fault gives instr_valid 1 cycle after accept.
- Back-to-back throughput is one instruction per 3 cycles using the HOLD-accept overlap.
- A mem_gnt and mem_rvalid in the same cycle in WAIT_GNT are not supported; the bus guarantees rvalid at least one cycle after gnt.
- Counter width is 8 bits. It saturates and does not wrap.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - A misaligned fetch_pc produces an immediate fault response with no bus access.
- Not defined:
  - fetch_pc[1:0] is ignored and the aligned word is fetched.
  - instr_fault comes only from mem_err or a timeout.

## Structure
- The package ifetch_pkg holds the state enum, the NOP constant 32'h00000013 and the counter width.
- One sub-module, ifetch_out_reg, holds instr, instr_pc and instr_fault and drives the valid/ready output stage.
- The FSM, counter and bus drive stay in the top module.

## Test plan
- Reset, then fetch_pc=0x0000_0000 with gnt in 0 cycles and rvalid 1 cycle later (rdata=0x0050_0093) -> instr_valid on the 3rd cycle after accept with instr=0x0050_0093, instr_pc=0, fault=0.
- instr_ready low for 5 cycles while in HOLD -> outputs stable; fetch_gnt=0 until the cycle instr_ready=1.
- flush 1 cycle after mem_gnt, then rvalid with rdata=0xDEAD_BEEF -> the data is discarded, instr_valid stays 0, and the next fetch of 0x4 returns its own data.
- No rvalid for TIMEOUT_CYCLES cycles -> instr_valid=1, fault=1, instr=0x0000_0013. A late rvalid afterwards is ignored.
- fetch_pc=0x0000_0006 with IFETCH_ALIGN_CHECK_EN defined -> no mem_req and fault=1 one cycle later. Without the macro -> mem_addr=0x0000_0004.
- rvalid with mem_err=1 -> fault=1 and instr=NOP. A later rst_n low during WAIT_GNT -> mem_req=0 next cycle.
